// File: rtl/seg7_pkg.sv
// seg7_pkg
// Shared definitions for the scanning 7-segment display driver:
//   - segment patterns (active high, bit 6 = a ... bit 0 = g)
//   - scan FSM state enum
//   - counter width helpers for the digit index and the prescaler
// Ports: none (package).
package seg7_pkg;

    localparam logic [6:0] SEG_0    = 7'b1111110;
    localparam logic [6:0] SEG_1    = 7'b0110000;
    localparam logic [6:0] SEG_2    = 7'b1101101;
    localparam logic [6:0] SEG_3    = 7'b1111001;
    localparam logic [6:0] SEG_4    = 7'b0110011;
    localparam logic [6:0] SEG_5    = 7'b1011011;
    localparam logic [6:0] SEG_6    = 7'b1011111;
    localparam logic [6:0] SEG_7    = 7'b1110000;
    localparam logic [6:0] SEG_8    = 7'b1111111;
    localparam logic [6:0] SEG_9    = 7'b1111011;
    localparam logic [6:0] SEG_DASH = 7'b0000001;
    localparam logic [6:0] SEG_OFF  = 7'b0000000;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SCAN = 1'b1
    } scan_state_t;

    localparam int MAX_DIGITS = 8;

    // Width of a counter holding 0..n-1; never narrower than one bit so a
    // single-digit bank or a tiny divider still gets a legal vector.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int MAX_IDX_W = cnt_width(MAX_DIGITS);

endpackage

// File: rtl/seg7_decode.sv
// seg7_decode
// Combinational BCD to 7-segment decoder with blanking.
// Ports:
//   bcd   in  4  digit value; 10..15 show a dash
//   blank in  1  forces all segments off
//   seg   out 7  segments, active high, seg[6]=a ... seg[0]=g
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [3:0] bcd,
    input  logic       blank,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_DASH;
        if (blank) begin
            seg = SEG_OFF;
        end else begin
            case (bcd)
                4'd0:    seg = SEG_0;
                4'd1:    seg = SEG_1;
                4'd2:    seg = SEG_2;
                4'd3:    seg = SEG_3;
                4'd4:    seg = SEG_4;
                4'd5:    seg = SEG_5;
                4'd6:    seg = SEG_6;
                4'd7:    seg = SEG_7;
                4'd8:    seg = SEG_8;
                4'd9:    seg = SEG_9;
                default: seg = SEG_DASH;
            endcase
        end
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver
// Time-multiplexed driver for NUM_DIGITS common-select 7-segment digits.
// A load strobe captures the BCD word into a shadow register; the shadow is
// committed to the displayed value only at frame start so a frame never
// shows a mix of old and new digits.
// Parameters:
//   NUM_DIGITS  digits scanned (1..8)
//   SCAN_DIV    clk cycles each digit stays selected (>= 2)
// Ports:
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   en         in   display enable; 0 blanks outputs and halts the scan
//   load       in   one-cycle strobe capturing bcd_in / dp_in
//   bcd_in     in   packed BCD, digit i at [4i+3:4i]
//   dp_in      in   decimal point per digit
//   seg        out  segments of selected digit, active high (a..g)
//   dp         out  decimal point of selected digit
//   an         out  one-hot digit select
//   frame_tick out  one-cycle pulse when digit 0 becomes selected
// Build option: define SEG7_LZ_BLANK_EN to enable leading-zero blanking.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int SCAN_DIV   = 1000
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      en,
    input  logic                      load,
    input  logic [4*NUM_DIGITS-1:0]   bcd_in,
    input  logic [NUM_DIGITS-1:0]     dp_in,
    output logic [6:0]                seg,
    output logic                      dp,
    output logic [NUM_DIGITS-1:0]     an,
    output logic                      frame_tick
);

    localparam int IDX_W = cnt_width(NUM_DIGITS);
    localparam int PRE_W = cnt_width(SCAN_DIV);
    // Selection arrays are padded to a power of two so idx indexes them
    // without range gaps; padding slots are never selected.
    localparam int SLOTS = 1 << IDX_W;

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(SCAN_DIV - 1);

    scan_state_t               state_reg, state_next;
    logic [PRE_W-1:0]          pre_reg, pre_next;
    logic [IDX_W-1:0]          idx_reg, idx_next;

    logic [4*NUM_DIGITS-1:0]   shadow_bcd_reg, shadow_bcd_next;
    logic [NUM_DIGITS-1:0]     shadow_dp_reg, shadow_dp_next;
    logic                      pending_reg, pending_next;
    logic [4*NUM_DIGITS-1:0]   disp_bcd_reg, disp_bcd_next;
    logic [NUM_DIGITS-1:0]     disp_dp_reg, disp_dp_next;

    logic [6:0]                seg_reg;
    logic                      dp_reg;
    logic [NUM_DIGITS-1:0]     an_reg;
    logic                      frame_tick_reg;

    logic                      frame_start;
    logic                      blank_out;

    // ---------------- scan FSM ----------------
    always_comb begin
        state_next  = state_reg;
        pre_next    = pre_reg;
        idx_next    = idx_reg;
        frame_start = 1'b0;
        blank_out   = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                pre_next = '0;
                idx_next = '0;
                if (en) begin
                    state_next  = ST_SCAN;
                    frame_start = 1'b1;
                end else begin
                    blank_out = 1'b1;
                end
            end
            ST_SCAN: begin
                if (!en) begin
                    state_next = ST_IDLE;
                    pre_next   = '0;
                    idx_next   = '0;
                    blank_out  = 1'b1;
                end else if (pre_reg == PRE_LAST) begin
                    pre_next = '0;
                    // With one digit IDX_LAST is 0, so every prescaler wrap
                    // lands here and starts a new frame.
                    if (idx_reg == IDX_LAST) begin
                        idx_next    = '0;
                        frame_start = 1'b1;
                    end else begin
                        idx_next = idx_reg + IDX_W'(1);
                    end
                end else begin
                    pre_next = pre_reg + PRE_W'(1);
                end
            end
            default: begin
                state_next = ST_IDLE;
                pre_next   = '0;
                idx_next   = '0;
                blank_out  = 1'b1;
            end
        endcase
    end

    // ---------------- shadow / commit ----------------
    always_comb begin
        shadow_bcd_next = shadow_bcd_reg;
        shadow_dp_next  = shadow_dp_reg;
        pending_next    = pending_reg;
        disp_bcd_next   = disp_bcd_reg;
        disp_dp_next    = disp_dp_reg;

        if (load) begin
            shadow_bcd_next = bcd_in;
            shadow_dp_next  = dp_in;
            pending_next    = 1'b1;
        end

        if (frame_start) begin
            pending_next = 1'b0;
            // A load coinciding with the commit edge bypasses the shadow.
            if (load) begin
                disp_bcd_next = bcd_in;
                disp_dp_next  = dp_in;
            end else if (pending_reg) begin
                disp_bcd_next = shadow_bcd_reg;
                disp_dp_next  = shadow_dp_reg;
            end
        end
    end

    // ---------------- digit selection ----------------
    // Outputs are computed from the next idx and next display value so the
    // digit and its pattern change on the same edge, including the commit.
    logic [3:0]             digit_arr [SLOTS];
    logic                   dp_arr    [SLOTS];
    logic                   lzb_arr   [SLOTS];
    logic [NUM_DIGITS-1:0]  an_sel;

`ifdef SEG7_LZ_BLANK_EN
    // lz_chain[i] = digit i and every digit above it are zero.
    logic [NUM_DIGITS:0]    lz_chain;
    assign lz_chain[NUM_DIGITS] = 1'b1;
`endif

    generate
        for (genvar gi = 0; gi < SLOTS; gi++) begin : g_slot
            if (gi < NUM_DIGITS) begin : g_real
                assign digit_arr[gi] = disp_bcd_next[4*gi +: 4];
                assign dp_arr[gi]    = disp_dp_next[gi];
                assign an_sel[gi]    = (idx_next == IDX_W'(gi));
`ifdef SEG7_LZ_BLANK_EN
                assign lz_chain[gi]  = lz_chain[gi+1] &&
                                       (disp_bcd_next[4*gi +: 4] == 4'd0);
                if (gi == 0) begin : g_d0
                    assign lzb_arr[gi] = 1'b0;
                end else begin : g_dn
                    assign lzb_arr[gi] = lz_chain[gi];
                end
`else
                assign lzb_arr[gi]   = 1'b0;
`endif
            end else begin : g_pad
                assign digit_arr[gi] = 4'd0;
                assign dp_arr[gi]    = 1'b0;
                assign lzb_arr[gi]   = 1'b0;
            end
        end
    endgenerate

    logic [6:0] seg_dec;

    seg7_decode u_decode (
        .bcd   (digit_arr[idx_next]),
        .blank (lzb_arr[idx_next]),
        .seg   (seg_dec)
    );

    // ---------------- registers ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= ST_IDLE;
            pre_reg        <= '0;
            idx_reg        <= '0;
            shadow_bcd_reg <= '0;
            shadow_dp_reg  <= '0;
            pending_reg    <= 1'b0;
            disp_bcd_reg   <= '0;
            disp_dp_reg    <= '0;
            seg_reg        <= '0;
            dp_reg         <= 1'b0;
            an_reg         <= '0;
            frame_tick_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            pre_reg        <= pre_next;
            idx_reg        <= idx_next;
            shadow_bcd_reg <= shadow_bcd_next;
            shadow_dp_reg  <= shadow_dp_next;
            pending_reg    <= pending_next;
            disp_bcd_reg   <= disp_bcd_next;
            disp_dp_reg    <= disp_dp_next;
            seg_reg        <= blank_out ? 7'd0 : seg_dec;
            dp_reg         <= blank_out ? 1'b0 : dp_arr[idx_next];
            an_reg         <= blank_out ? '0 : an_sel;
            frame_tick_reg <= frame_start;
        end
    end

    assign seg        = seg_reg;
    assign dp         = dp_reg;
    assign an         = an_reg;
    assign frame_tick = frame_tick_reg;

endmodule

// File: doc/seg7_scan_driver.md
# seg7_scan_driver

Time-multiplexed driver for a parametrised bank of common-select 7-segment digits. It is the scanning successor to the single-digit combinational BCD-to-7-segment decoder. A packed BCD word is loaded into a shadow register and committed only at frame boundaries, so the display never tears. The block then cycles a one-hot digit select at a programmable refresh rate. It sits between the numeric datapath (counters, timers) and the board display pins.

## Interface
- NUM_DIGITS, 4, number of digits scanned; legal range 1..8
- SCAN_DIV, 1000, clk cycles each digit stays selected; must be ≥2
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- en  input  1  display enable; 0 blanks the display and halts the scan
- load  input  1  one-cycle strobe that captures bcd_in and dp_in
- bcd_in  input  4*NUM_DIGITS  packed BCD; digit i is bcd_in[4i+3:4i], digit 0 is least significant
- dp_in  input  NUM_DIGITS  decimal point per digit
- seg  output  7  segments, active high; seg[6]=a … seg[0]=g
- dp  output  1  decimal point of the selected digit, active high
- an  output  NUM_DIGITS  one-hot digit select, active high
- frame_tick  output  1  one-cycle pulse when digit 0 becomes selected

## Operation
- Registers:
  - shadow: shadow_bcd, shadow_dp, pending.
  - display: disp_bcd, disp_dp.
  - scan: prescaler 0..SCAN_DIV-1, idx 0..NUM_DIGITS-1.
- load=1 captures bcd_in and dp_in into the shadow registers and sets pending. A second load before commit overwrites the first (last wins).
- Commit copies shadow into display and clears pending. It happens only at a frame-start edge.
  - If load=1 on the commit edge, bcd_in and dp_in are committed directly.
- FSM has two states: IDLE and SCAN.
  - IDLE: an, seg and dp are 0; prescaler=0, idx=0. If en=1, go to SCAN at the next edge; that edge is a frame-start edge.
  - SCAN: prescaler increments each cycle. At SCAN_DIV-1 it wraps to 0 and idx advances. idx wraps from NUM_DIGITS-1 to 0; that wrap is a frame-start edge. If en=0, go to IDLE at the next edge, and outputs blank at that edge.
- The frame-start edge does three things:
  - performs the commit,
  - sets frame_tick=1 for one cycle,
  - selects digit 0 using the just-committed value.
- Decode of 0–9 to seg[6:0]:
  - 0 1111110, 1 0110000, 2 1101101, 3 1111001, 4 0110011
  - 5 1011011, 6 1011111, 7 1110000, 8 1111111, 9 1111011
- Codes 10–15 display a dash: 0000001.
- NUM_DIGITS=1: idx is constant 0, and every prescaler wrap is a frame-start edge.

## Timing
- Reset: an=0, seg=0, dp=0, frame_tick=0; all internal registers 0; FSM in IDLE. Reset asserted mid-frame discards the scan position and pending data.
- Outputs are registered. an, seg and dp change on the same edge that updates idx.
- Each digit is selected for exactly SCAN_DIV cycles. The frame period is NUM_DIGITS*SCAN_DIV cycles, so frame_tick fires every NUM_DIGITS*SCAN_DIV cycles while en stays 1.
- Latency from load to visible: up to one frame plus one cycle.
- en 1→0 blanks outputs one edge later. en 0→1 selects digit 0 one edge later.

## Configuration
- Macro SEG7_LZ_BLANK_EN: leading-zero blanking.
  - Defined: starting from digit NUM_DIGITS-1, each digit whose value is 0 and whose higher digits are all 0 (or blanked) drives seg=0. an still selects it, and dp still follows disp_dp. Digit 0 is never blanked.
  - Undefined: every digit is decoded normally.

## Structure
- Package seg7_pkg holds:
  - the segment-pattern constants (digits 0–9 and dash),
  - the FSM state enum,
  - localparams for the idx and prescaler widths ($clog2).
- Sub-module seg7_decode: combinational 4-bit to 7-segment decoder with a blank input. It is instantiated once, on the idx-selected digit.

## Test plan
Bench settings: NUM_DIGITS=4, SCAN_DIV=4.
- **Reset:** assert rst_n=0 mid-scan → an=0000, seg=0000000, dp=0, frame_tick=0 immediately and held while reset is asserted.
- **Normal scan:** load 16'h1234, en=1 → on the frame-start edge an=0001, seg=0110011 for 4 cycles; then an=0010/1111001, an=0100/1101101, an=1000/0110000; frame_tick every 16 cycles.
- **Mid-frame load:** load 16'h5678 while idx=2 → digits 2 and 3 still show 2 and 1; the next frame shows 8, 7, 6, 5.
- **Invalid BCD and decimal point:** load digit 0 = 4'hA with dp_in=0001 → on an=0001, seg=0000001 and dp=1.
- **Leading-zero blanking:** load 16'h0050.
  - With SEG7_LZ_BLANK_EN: digits 3 and 2 give seg=0000000, digit 1 gives 1011011, digit 0 gives 1111110.
  - Without the macro: digit 3 gives 1111110.
- **Enable toggle:** drop en at idx=1 → next edge an=0000, seg=0. Raise en again → next edge an=0001 with frame_tick=1.
